// File: rtl/demux_pkg.sv
// Shared constants, state encoding and select decode for the round-robin demux dispatcher.
// Build option DEMUX_SKIP_BUSY_EN is consumed only by rr_next_sel.
package demux_pkg;

    localparam int DEMUX_CH    = 8;
    localparam int DEMUX_SEL_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    function automatic logic [DEMUX_CH-1:0] onehot8(input logic [DEMUX_SEL_W-1:0] sel);
        logic [DEMUX_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_rr_dispatch_rr_next_sel.sv
// Picks the channel for the next accepted word from the rotation pointer.
// DEMUX_SKIP_BUSY_EN: skip lanes whose consumer is not ready; otherwise strict rotation.
module rr_next_sel
    import demux_pkg::*;
(
    input  logic [DEMUX_SEL_W-1:0] ptr,
    input  logic [DEMUX_CH-1:0]    ch_ready,
    output logic [DEMUX_SEL_W-1:0] nxt
);

`ifdef DEMUX_SKIP_BUSY_EN
    logic                   found;
    logic [DEMUX_SEL_W-1:0] cand;

    // First ready lane at or after ptr; falls back to ptr when every lane is busy.
    always_comb begin
        nxt   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < DEMUX_CH; k++) begin
            cand = ptr + DEMUX_SEL_W'(k);
            if (!found && ch_ready[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end
`else
    logic unused_ch_ready;

    assign nxt             = ptr;
    assign unused_ch_ready = ^ch_ready;
`endif

endmodule

// File: rtl/demux_rr_dispatch.sv
// Round-robin dispatcher: one-word output register feeding an 8-way demux, lanes served in turn.
// Build option DEMUX_SKIP_BUSY_EN (in rr_next_sel) lets the rotation skip stalled lanes.
//
//   state | meaning
//   EMPTY | no word held, input accepted unconditionally
//   FULL  | word held on lane cur_sel, replaced only in the cycle it is delivered
module demux_rr_dispatch
    import demux_pkg::*;
#(
    parameter int width = 8,
    parameter int snum  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [width-1:0]    i,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic                flush,
    input  logic [DEMUX_CH-1:0] ch_ready,
    output logic [width-1:0]    o0,
    output logic [width-1:0]    o1,
    output logic [width-1:0]    o2,
    output logic [width-1:0]    o3,
    output logic [width-1:0]    o4,
    output logic [width-1:0]    o5,
    output logic [width-1:0]    o6,
    output logic [width-1:0]    o7,
    output logic [DEMUX_CH-1:0] o_valid,
    output logic [snum-1:0]     sel,
    output logic [15:0]         disp_cnt
);

    state_e                 state_q,    state_d;
    logic [width-1:0]       out_data_q, out_data_d;
    logic [DEMUX_SEL_W-1:0] cur_sel_q,  cur_sel_d;
    logic [DEMUX_SEL_W-1:0] ptr_q,      ptr_d;
    logic [15:0]            disp_cnt_q, disp_cnt_d;

    logic [DEMUX_SEL_W-1:0] nxt;
    logic                   deliver;
    logic                   load;
    logic [width-1:0]       o_arr [DEMUX_CH];

    rr_next_sel u_rr_next_sel (
        .ptr      (ptr_q),
        .ch_ready (ch_ready),
        .nxt      (nxt)
    );

    assign deliver = (state_q == FULL) && ch_ready[cur_sel_q];
    assign load    = i_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            cur_sel_q  <= '0;
            ptr_q      <= '0;
            disp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            cur_sel_q  <= cur_sel_d;
            ptr_q      <= ptr_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        cur_sel_d  = cur_sel_q;
        ptr_d      = ptr_q;
        disp_cnt_d = disp_cnt_q;
        // Flush drops the held word without counting a same-cycle delivery.
        if (flush) begin
            state_d = EMPTY;
            ptr_d   = '0;
        end else begin
            if (deliver) begin
                disp_cnt_d = disp_cnt_q + 16'd1;
            end
            if (load) begin
                state_d    = FULL;
                out_data_d = i;
                cur_sel_d  = nxt;
                ptr_d      = nxt + DEMUX_SEL_W'(1);
            end else if (deliver) begin
                state_d = EMPTY;
            end
        end
    end

    // Outputs are forced quiet while reset is asserted, before the registers clear.
    always_comb begin
        o_valid = '0;
        i_ready = 1'b0;
        sel     = '0;
        if (!rst) begin
            if (state_q == FULL) begin
                o_valid = onehot8(cur_sel_q);
            end
            i_ready = !flush && ((state_q == EMPTY) || deliver);
            sel     = snum'(cur_sel_q);
        end
        for (int k = 0; k < DEMUX_CH; k++) begin
            o_arr[k] = o_valid[k] ? out_data_q : '0;
        end
    end

    assign o0       = o_arr[0];
    assign o1       = o_arr[1];
    assign o2       = o_arr[2];
    assign o3       = o_arr[3];
    assign o4       = o_arr[4];
    assign o5       = o_arr[5];
    assign o6       = o_arr[6];
    assign o7       = o_arr[7];
    assign disp_cnt = disp_cnt_q;

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Directed bench for demux_rr_dispatch with a small reference model of the held word and counters.
module tb_demux_rr_dispatch;

    logic        clk;
    logic        rst;
    logic [7:0]  i;
    logic        i_valid;
    logic        i_ready;
    logic        flush;
    logic [7:0]  ch_ready;
    logic [7:0]  o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0]  o_valid;
    logic [2:0]  sel;
    logic [15:0] disp_cnt;
    logic [63:0] outs_obs;

    int vectors     = 0;
    int miscompares = 0;

    bit          exp_full;
    int          exp_ch;
    int          exp_ptr;
    logic [7:0]  exp_data;
    logic [15:0] exp_cnt;
    logic [15:0] saved_cnt;

    demux_rr_dispatch #(.width(8), .snum(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .i        (i),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .flush    (flush),
        .ch_ready (ch_ready),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .o4       (o4),
        .o5       (o5),
        .o6       (o6),
        .o7       (o7),
        .o_valid  (o_valid),
        .sel      (sel),
        .disp_cnt (disp_cnt)
    );

    assign outs_obs = {o7, o6, o5, o4, o3, o2, o1, o0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int model_nxt(input int p, input logic [7:0] rdy);
`ifdef DEMUX_SKIP_BUSY_EN
        for (int k = 0; k < 8; k++) begin
            if (rdy[(p + k) % 8]) return (p + k) % 8;
        end
`endif
        return p;
    endfunction

    // Advance the model by one clock using the currently driven inputs, then cross the edge.
    task automatic tick();
        bit dlv;
        bit ld;
        int nx;
        dlv = exp_full && ch_ready[exp_ch];
        ld  = !rst && !flush && i_valid && (!exp_full || dlv);
        nx  = model_nxt(exp_ptr, ch_ready);
        if (rst) begin
            exp_full = 0; exp_ch = 0; exp_ptr = 0; exp_data = '0; exp_cnt = '0;
        end else if (flush) begin
            exp_full = 0; exp_ptr = 0;
        end else begin
            if (dlv) exp_cnt = exp_cnt + 16'd1;
            if (ld) begin
                exp_data = i; exp_ch = nx; exp_ptr = (nx + 1) % 8; exp_full = 1;
            end else if (dlv) begin
                exp_full = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [7:0]  ev;
        logic [63:0] eo;
        logic        er;
        ev = exp_full ? (8'h01 << exp_ch) : 8'h00;
        eo = '0;
        if (exp_full) eo[exp_ch*8 +: 8] = exp_data;
        er = !rst && !flush && (!exp_full || ch_ready[exp_ch]);
        chk({tag, "_o_valid"},  64'(o_valid),  64'(ev));
        chk({tag, "_outs"},     outs_obs,      eo);
        chk({tag, "_sel"},      64'(sel),      64'(exp_ch));
        chk({tag, "_disp_cnt"}, 64'(disp_cnt), 64'(exp_cnt));
        chk({tag, "_i_ready"},  64'(i_ready),  64'(er));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i = '0; ch_ready = 8'hFF;
        exp_full = 0; exp_ch = 0; exp_ptr = 0; exp_data = '0; exp_cnt = '0;
        #1;
        chk("rst_i_ready", 64'(i_ready), 64'd0);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_sel",     64'(sel),     64'd0);
        chk("rst_outs",    outs_obs,     64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_all("post_rst");
        chk("post_rst_cnt", 64'(disp_cnt), 64'd0);

        // Full-speed stream 0x10..0x19 through lanes 0..7,0,1.
        for (int w = 0; w < 10; w++) begin
            i = 8'h10 + 8'(w); i_valid = 1'b1;
            #1;
            chk("t1_i_ready", 64'(i_ready), 64'd1);
            tick();
            check_all("t1");
            chk("t1_lane", 64'(sel), 64'(w % 8));
        end
        i_valid = 1'b0;
        tick();
        check_all("t1_drain");
        chk("t1_cnt", 64'(disp_cnt), 64'd10);

        // 0xA5 held on lane 2 while its consumer stalls for 4 cycles.
        i = 8'hA5; i_valid = 1'b1; ch_ready = 8'hFF;
        tick();
        i_valid = 1'b0; ch_ready = 8'hFB;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("t2_o2",      64'(o2),      64'hA5);
            chk("t2_o_valid", 64'(o_valid), 64'h04);
            chk("t2_i_ready", 64'(i_ready), 64'd0);
            check_all("t2_hold");
            tick();
        end
        ch_ready = 8'hFF;
        #1;
        chk("t2_release_i_ready", 64'(i_ready), 64'd1);
        tick();
        check_all("t2_done");
        chk("t2_cnt", 64'(disp_cnt), 64'd11);

        // Pointer is 3; lanes 3 and 4 busy.
        ch_ready = 8'hE7; i = 8'h33; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check_all("t3_load");
`ifdef DEMUX_SKIP_BUSY_EN
        chk("t3_skip_lane", 64'(sel), 64'd5);
        tick();
        check_all("t3_skip_done");
`else
        chk("t3_strict_lane", 64'(sel), 64'd3);
        tick();
        check_all("t3_stall0");
        tick();
        check_all("t3_stall1");
        chk("t3_stall_o_valid", 64'(o_valid), 64'h08);
        ch_ready = 8'hFF;
        tick();
        check_all("t3_done");
`endif
        chk("t3_cnt", 64'(disp_cnt), 64'd12);

        // Walk the pointer to 6 and hold 0x66 there.
        ch_ready = 8'hFF; i_valid = 1'b1;
        while (exp_ptr != 6) begin
            i = 8'h40 + 8'(exp_ptr);
            tick();
            check_all("t4_walk");
        end
        i = 8'h66;
        tick();
        i_valid = 1'b0; ch_ready = 8'h00;
        #1;
        check_all("t4_held");
        chk("t4_lane6", 64'(sel), 64'd6);
        chk("t4_o6",    64'(o6),  64'h66);
        saved_cnt = disp_cnt;

        // Flush beats both the input and a same-cycle delivery.
        flush = 1'b1; i_valid = 1'b1; i = 8'h77; ch_ready = 8'hFF;
        #1;
        chk("t5_flush_i_ready", 64'(i_ready), 64'd0);
        tick();
        flush = 1'b0; i_valid = 1'b0;
        #1;
        check_all("t5_flushed");
        chk("t5_o_valid", 64'(o_valid),  64'd0);
        chk("t5_cnt",     64'(disp_cnt), 64'(saved_cnt));
        i = 8'h88; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check_all("t5_reload");
        chk("t5_lane0", 64'(sel), 64'd0);
        chk("t5_o0",    64'(o0),  64'h88);
        tick();
        check_all("t5_drain");

        // Run the counter up to 0xFFFF with a word left held, then wrap it.
        ch_ready = 8'hFF; i_valid = 1'b1;
        while (exp_cnt != 16'hFFFF) begin
            i = exp_cnt[7:0];
            tick();
        end
        i_valid = 1'b0; ch_ready = 8'h00;
        #1;
        check_all("t6_full_ffff");
        chk("t6_cnt_ffff", 64'(disp_cnt), 64'hFFFF);
        ch_ready = 8'hFF;
        tick();
        check_all("t6_wrap");
        chk("t6_cnt_wrap", 64'(disp_cnt), 64'd0);

        // Reset while a word is held discards it.
        i = 8'hC3; i_valid = 1'b1;
        tick();
        i = 8'hC4;
        tick();
        i_valid = 1'b0; ch_ready = 8'h00;
        #1;
        check_all("t7_held");
        chk("t7_cnt", 64'(disp_cnt), 64'd1);
        rst = 1'b1;
        #1;
        chk("t7_during_o_valid", 64'(o_valid), 64'd0);
        chk("t7_during_outs",    outs_obs,     64'd0);
        chk("t7_during_i_ready", 64'(i_ready), 64'd0);
        chk("t7_during_sel",     64'(sel),     64'd0);
        tick();
        chk("t7_after_o_valid",  64'(o_valid),  64'd0);
        chk("t7_after_outs",     outs_obs,      64'd0);
        chk("t7_after_cnt",      64'(disp_cnt), 64'd0);
        chk("t7_after_sel",      64'(sel),      64'd0);
        rst = 1'b0; ch_ready = 8'hFF;
        #1;
        check_all("t7_released");
        i = 8'hD1; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check_all("t7_first");
        chk("t7_first_lane", 64'(sel), 64'd0);
        chk("t7_first_o0",   64'(o0),  64'hD1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_rr_dispatch.md
# demux_rr_dispatch

Round-robin dispatcher in front of the 1-to-8, 8-bit demux datapath: accepts a valid/ready input stream and sequences the demux select so that consecutive words go to output channels 0,1,2,…,7,0,… in turn. A one-word output register decouples the input from per-channel backpressure. The block sits between a single producer and eight consumer lanes.

## Interface
- `width`, default 8: data width.
- `snum`, default 3: select width; channel count is fixed at 8.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i` in width: input data.
- `i_valid` in 1: input word present.
- `i_ready` out 1: block accepts the word this cycle.
- `flush` in 1: synchronous clear of the held word and the pointer.
- `ch_ready` in 8: per-channel consumer ready.
- `o0`..`o7` out width each: channel data; zero when that channel is not selected or nothing is held.
- `o_valid` out 8: one-hot per-channel valid; all zero when empty.
- `sel` out snum: channel of the held word (`cur_sel`).
- `disp_cnt` out 16: count of words delivered to consumers, wraps.

## Operation
- State: `EMPTY` or `FULL`. Registers: `out_data`, `cur_sel`, `ptr` (next channel in rotation, 3 bits), `disp_cnt`.
- `o_valid[k] = FULL && cur_sel==k`. `ok = o_valid[k] ? out_data : 0`.
- Delivery (`deliver`): `FULL && ch_ready[cur_sel]`.
- `i_ready = !rst && !flush && (EMPTY || deliver)`.
- Load (`i_valid && i_ready`): `out_data <= i`, `cur_sel <= nxt`, `ptr <= nxt+1` (mod 8, 7 wraps to 0), state `FULL`.
- `deliver` without load: state `EMPTY`. `deliver` with load: stays `FULL` with the new word.
- `disp_cnt` increments by 1 on every `deliver` and wraps from 0xFFFF to 0.
- `nxt` is selected by the configuration (see below). Default: `nxt = ptr`.
- `flush`: state `EMPTY`, `ptr <= 0`. `out_data`, `cur_sel` and `disp_cnt` are held. A delivery in the same cycle is not counted. Flush wins over `i_valid`.
- Reset:
  - Register values: state `EMPTY`, `out_data=0`, `cur_sel=0`, `ptr=0`, `disp_cnt=0`.
  - Output values: all `ok=0`, `o_valid=0`, `sel=0`, `i_ready=0` during reset.
  - Reset mid-transfer discards the held word.

## Timing
- Latency: a word accepted at edge N is presented on its channel from cycle N+1.
- Throughput: 1 word/cycle while the selected channel is ready.
- Hold rule: once presented, the word, `cur_sel` and `o_valid` stay stable until delivered or until reset/flush.
- `i_ready` combinationally depends on `ch_ready[cur_sel]`. There is no combinational path from `i_valid` to any output.

## Configuration
- `DEMUX_SKIP_BUSY_EN` defined:
  - `nxt` is the first channel c in the order ptr, ptr+1, …, ptr+7 (mod 8) with `ch_ready[c]=1`.
  - If no channel is ready, `nxt = ptr`.
  - Busy lanes are skipped, so throughput is kept when some consumers stall.
- Undefined: strict rotation, `nxt = ptr`. A stalled lane blocks the stream.

## Structure
- Shared package `demux_pkg`:
  - constants `DEMUX_CH = 8` and `DEMUX_SEL_W = 3`;
  - state enum `{EMPTY, FULL}`;
  - function `onehot8(sel)`.
- One sub-module, `rr_next_sel`: combinational computation of `nxt` from `ptr` and `ch_ready`. The macro affects only this sub-module.
- Output gating is equivalent to the dataflow demux and is done inline.

## Test plan
- Reset, all `ch_ready=FF`, stream 0x10..0x19 with `i_valid` high:
  - channels 0..7 then 0,1 receive the stream in order;
  - one word per cycle; `disp_cnt=10`; `i_ready` stays 1.
- Input 0xA5 to channel 2 with `ch_ready[2]=0` for 4 cycles:
  - `o2=0xA5` and `o_valid=04` are held;
  - `i_ready=0`;
  - all other `ok=0`;
  - delivered the cycle `ch_ready[2]` rises.
- `DEMUX_SKIP_BUSY_EN`, `ptr=3`, `ch_ready=0b1110_0111`: next word goes to channel 5, and `ptr` becomes 6.
- Strict mode, same `ch_ready`: word goes to channel 3 and stalls there until `ch_ready[3]=1`.
- Word held on channel 6, assert `flush` together with `i_valid`:
  - next cycle `o_valid=0`, `ptr=0`;
  - word not accepted; `disp_cnt` unchanged;
  - next accepted word goes to channel 0.
- Assert `rst` while `FULL` with `disp_cnt=0xFFFF`:
  - all outputs are zero next cycle.
- Separately, from `disp_cnt=0xFFFF`, one delivery wraps the counter to 0.
